screen_fetch_arbiter: RTL and testbench

- Shares the single-port Hack screen RAM (8192 x 16) between CPU load/store traffic and display refresh.
- Prefetches one 16-pixel word ahead of the raster.
- Serialises screen words into a 1-bit pixel stream for the VGA timing generator's vga_in.
- Sits between the VGA timing generator (consumes its pixel_row, pixel_column and video_on) and the screen RAM / CPU memory-map decoder.

---
 rtl/vga_pkg.sv | 32 +++
 rtl/screen_fetch_arbiter_if.sv | 28 ++
 rtl/screen_fetch_arbiter_pixel_serializer.sv | 41 ++++
 rtl/screen_fetch_arbiter.sv | 95 +++++++++
 tb/tb_screen_fetch_arbiter.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Raster geometry of the Hack screen window and the fetch arbiter state encoding,
// shared by the arbiter, its pixel serializer and the bus interface.
package vga_pkg;

  localparam int PIX_W          = 10;
  localparam int H_OFFSET       = 64;
  localparam int V_OFFSET       = 112;
  localparam int SCREEN_W       = 512;
  localparam int SCREEN_H       = 256;
  localparam int ADDR_W         = 13;
  localparam int DATA_W         = 16;
  localparam int WORDS_PER_LINE = SCREEN_W / DATA_W;
  localparam int WORD_SHIFT     = $clog2(WORDS_PER_LINE);
  localparam int GROUP_SHIFT    = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    CPU  = 2'd2
  } arb_state_t;

  // Screen word holding raster position (row, col); wraps modulo the RAM size.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [PIX_W-1:0] row,
                                                  input logic [PIX_W-1:0] col);
    logic [PIX_W-1:0] row_off;
    logic [PIX_W-1:0] col_off;
    row_off = row - PIX_W'(V_OFFSET);
    col_off = col - PIX_W'(H_OFFSET);
    return (ADDR_W'(row_off) << WORD_SHIFT) + ADDR_W'(col_off >> GROUP_SHIFT);
  endfunction

endpackage

// File: rtl/screen_fetch_arbiter_if.sv
// CPU request/response and screen RAM port bundle.
// master = the arbiter side, slave = CPU memory-map decoder plus screen RAM.
interface screen_fetch_arbiter_if;
  import vga_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/screen_fetch_arbiter_pixel_serializer.sv
// Holds the prefetched screen word and shifts it out LSB-first (leftmost pixel first)
// across each 16-pixel group, forcing black outside the screen window.
module pixel_serializer
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              disp_cycle,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              in_win,
  input  logic              word_start,
  output logic              pixel_out
);

  logic              capture;
  logic [DATA_W-1:0] next_word;
  logic [DATA_W-1:0] shift;

  // RAM data appears the cycle after the display read, so capture is a one-cycle delay of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      capture   <= 1'b0;
      next_word <= '0;
      shift     <= '0;
      pixel_out <= 1'b0;
    end else begin
      capture <= disp_cycle;
      if (capture) next_word <= mem_rdata;
      if (!in_win) begin
        pixel_out <= 1'b0;
      end else if (word_start) begin
        pixel_out <= next_word[0];
        shift     <= next_word >> 1;
      end else begin
        pixel_out <= shift[0];
        shift     <= shift >> 1;
      end
    end
  end

endmodule

// File: rtl/screen_fetch_arbiter.sv
// Shares the single-port screen RAM between CPU accesses and a one-word-ahead display
// prefetch, and serialises the fetched words into the VGA pixel stream.
module screen_fetch_arbiter
  import vga_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PIX_W-1:0]       pixel_row,
  input  logic [PIX_W-1:0]       pixel_column,
  input  logic                   video_on,
  screen_fetch_arbiter_if.master bus,
  output logic                   pixel_out
);

  arb_state_t        state;
  logic              fetch_pend;
  logic [ADDR_W-1:0] fetch_addr;
  logic              row_in;
  logic              col_in;
  logic              in_win;
  logic              trigger;
  logic              cpu_grant;
  logic [PIX_W-1:0]  ahead_col;
  logic [ADDR_W-1:0] target;

  assign row_in = (pixel_row >= PIX_W'(V_OFFSET)) &&
                  (pixel_row <  PIX_W'(V_OFFSET + SCREEN_H));
  assign col_in = (pixel_column >= PIX_W'(H_OFFSET)) &&
                  (pixel_column <  PIX_W'(H_OFFSET + SCREEN_W));
  assign in_win = video_on && row_in && col_in;

  // One group ahead of the raster: col 48 fetches word 0, col 544 fetches word 31.
  assign trigger = row_in &&
                   (pixel_column >= PIX_W'(H_OFFSET - DATA_W)) &&
                   (pixel_column <= PIX_W'(H_OFFSET + SCREEN_W - 2 * DATA_W)) &&
                   (pixel_column[3:0] == 4'd0);
  assign ahead_col = pixel_column + PIX_W'(DATA_W);
  assign target    = word_addr(pixel_row, ahead_col);

  // The ack cycle is a turnaround, and a fresh trigger keeps the display ahead of the CPU.
  assign cpu_grant = bus.cpu_req && !bus.cpu_ack && (state != CPU) && !fetch_pend && !trigger;

  assign bus.cpu_rdata = bus.cpu_ack ? bus.mem_rdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      fetch_pend    <= 1'b0;
      fetch_addr    <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.cpu_ack <= (state == CPU);
      if (trigger) begin
        fetch_pend <= 1'b1;
        fetch_addr <= target;
      end else begin
        fetch_pend <= 1'b0;
      end
      if (fetch_pend) begin
        state         <= DISP;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= fetch_addr;
        bus.mem_wdata <= '0;
      end else if (cpu_grant) begin
        state         <= CPU;
        bus.mem_en    <= 1'b1;
        bus.mem_we    <= bus.cpu_we;
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_wdata;
      end else begin
        state         <= IDLE;
        bus.mem_en    <= 1'b0;
        bus.mem_we    <= 1'b0;
        bus.mem_addr  <= '0;
        bus.mem_wdata <= '0;
      end
    end
  end

  pixel_serializer u_serializer (
    .clk        (clk),
    .reset_n    (reset_n),
    .disp_cycle (state == DISP),
    .mem_rdata  (bus.mem_rdata),
    .in_win     (in_win),
    .word_start (pixel_column[3:0] == 4'd0),
    .pixel_out  (pixel_out)
  );

endmodule

// File: tb/tb_screen_fetch_arbiter.sv
// Self-checking bench: raster lines checked pixel by pixel against a screen-memory
// shadow, with randomized CPU traffic competing for the RAM port.
module tb_screen_fetch_arbiter;
  import vga_pkg::*;

  localparam int LINE_LEN = 660;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [PIX_W-1:0]  pixel_row;
  logic [PIX_W-1:0]  pixel_column;
  logic              video_on;
  logic              pixel_out;

  logic              pre_we;
  logic [ADDR_W-1:0] pre_addr;
  logic [DATA_W-1:0] pre_data;
  logic [DATA_W-1:0] ram    [0:8191];
  logic [DATA_W-1:0] shadow [0:8191];
  logic [ADDR_W-1:0] seen_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  screen_fetch_arbiter_if bus ();

  screen_fetch_arbiter dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pixel_row    (pixel_row),
    .pixel_column (pixel_column),
    .video_on     (video_on),
    .bus          (bus.master),
    .pixel_out    (pixel_out)
  );

  always #5 clk = ~clk;

  // Synchronous single-port screen RAM, with a backdoor load port used while in reset.
  always @(posedge clk) begin
    if (pre_we) begin
      ram[pre_addr] <= pre_data;
    end else if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string when);
    check_output({when, " cpu_ack"},   32'(bus.cpu_ack),   32'd0);
    check_output({when, " cpu_rdata"}, 32'(bus.cpu_rdata), 32'd0);
    check_output({when, " mem_en"},    32'(bus.mem_en),    32'd0);
    check_output({when, " mem_we"},    32'(bus.mem_we),    32'd0);
    check_output({when, " mem_addr"},  32'(bus.mem_addr),  32'd0);
    check_output({when, " mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
    check_output({when, " pixel_out"}, 32'(pixel_out),     32'd0);
  endtask

  task automatic apply_stimulus(input int row, input int col);
    pixel_row    = PIX_W'(row);
    pixel_column = PIX_W'(col);
    video_on     = (row < 480) && (col < 640);
  endtask

  // Expected pixel straight from the screen definition: leftmost pixel is bit 0.
  function automatic logic exp_pixel(input int row, input int col);
    logic [DATA_W-1:0] w;
    if (row >= V_OFFSET && row < V_OFFSET + SCREEN_H && row < 480 &&
        col >= H_OFFSET && col < H_OFFSET + SCREEN_W && col < 640) begin
      w = shadow[(row - V_OFFSET) * WORDS_PER_LINE + (col - H_OFFSET) / DATA_W];
      return w[(col - H_OFFSET) % DATA_W];
    end
    return 1'b0;
  endfunction

  // Drives one raster line; pixel_out is checked one cycle after its column.
  task automatic run_line(input int row, output int row_reads, output int any_en);
    int base;
    int prev_col;
    base      = (row - V_OFFSET) * WORDS_PER_LINE;
    row_reads = 0;
    any_en    = 0;
    prev_col  = -1;
    for (int col = 0; col <= LINE_LEN; col++) begin
      @(negedge clk);
      if (prev_col >= 0)
        check_output($sformatf("pixel r%0d c%0d", row, prev_col),
                     32'(pixel_out), 32'(exp_pixel(row, prev_col)));
      if (bus.mem_en) begin
        any_en++;
        if (!bus.mem_we && int'(bus.mem_addr) >= base && int'(bus.mem_addr) < base + WORDS_PER_LINE)
          row_reads++;
      end
      if (col < LINE_LEN) apply_stimulus(row, col);
      prev_col = col;
    end
  endtask

  task automatic cpu_start(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  // Waits (bounded) for cpu_ack, counting RAM accesses that match the pending request.
  task automatic cpu_wait(input int limit, output logic [DATA_W-1:0] rdata, output int lat,
                          output int hits, output int we_cyc, output bit ok);
    lat = 0; hits = 0; we_cyc = 0; ok = 1'b0; rdata = '0;
    seen_q.delete();
    while (lat < limit && !ok) begin
      @(negedge clk);
      lat++;
      if (bus.mem_en) seen_q.push_back(bus.mem_addr);
      if (bus.mem_en && bus.mem_we) we_cyc++;
      if (bus.mem_en && bus.mem_addr == bus.cpu_addr && bus.mem_we == bus.cpu_we &&
          (!bus.cpu_we || bus.mem_wdata == bus.cpu_wdata))
        hits++;
      if (bus.cpu_ack) begin
        ok    = 1'b1;
        rdata = bus.cpu_rdata;
      end
    end
  endtask

  initial begin
    int rr, ae, lat, hits, wec;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] v;
    bit ok;

    reset_n = 1'b0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    apply_stimulus(0, 0);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");

    for (int i = 0; i < 8192; i++) begin
      v = 16'($urandom);
      if (i == 0) v = 16'h0001;
      if (i == 1) v = 16'h8000;
      shadow[i] = v;
      pre_we = 1'b1; pre_addr = ADDR_W'(i); pre_data = v;
      @(negedge clk);
    end
    pre_we  = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    $display("[TB] memory loaded, reset released");

    run_line(111, rr, ae);
    check_output("row111 mem_en count", 32'(ae), 32'd0);
    run_line(112, rr, ae);
    check_output("row112 display reads", 32'(rr), 32'd32);
    run_line(368, rr, ae);
    check_output("row368 mem_en count", 32'(ae), 32'd0);

    apply_stimulus(0, 0);
    cpu_start(1'b1, 13'h1FFF, 16'hA5A5);
    cpu_wait(8, rd, lat, hits, wec, ok);
    check_output("write ack seen", 32'(ok), 32'd1);
    check_output("write ack latency", 32'(lat), 32'd2);
    check_output("write access count", 32'(hits), 32'd1);
    check_output("write we cycles", 32'(wec), 32'd1);
    shadow[13'h1FFF] = 16'hA5A5;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    cpu_start(1'b0, 13'h1FFF, 16'h0000);
    cpu_wait(8, rd, lat, hits, wec, ok);
    check_output("readback ack seen", 32'(ok), 32'd1);
    check_output("readback latency", 32'(lat), 32'd2);
    check_output("readback data", 32'(rd), 32'h0000A5A5);
    bus.cpu_req = 1'b0;
    @(negedge clk);

    run_line(367, rr, ae);
    check_output("row367 display reads", 32'(rr), 32'd32);

    // CPU request lands in the same cycle as the col-48 trigger of row 112.
    fork
      begin
        run_line(112, rr, ae);
        check_output("collision row reads", 32'(rr), 32'd32);
      end
      begin : collide_cpu
        logic [DATA_W-1:0] crd;
        int cl, ch, cw;
        bit cok;
        repeat (49) @(negedge clk);
        cpu_start(1'b0, 13'h1234, 16'h0000);
        cpu_wait(8, crd, cl, ch, cw, cok);
        check_output("collision ack seen", 32'(cok), 32'd1);
        check_output("collision latency", 32'(cl), 32'd4);
        check_output("collision first access", 32'(seen_q.size() > 0 ? seen_q[0] : 13'h1FFF), 32'h0000);
        check_output("collision second access", 32'(seen_q.size() > 1 ? seen_q[1] : 13'h0000), 32'h1234);
        check_output("collision read data", 32'(crd), 32'(shadow[13'h1234]));
        bus.cpu_req = 1'b0;
      end
    join

    // CPU keeps cpu_req high across back-to-back random requests for a whole line.
    fork
      begin
        run_line(113, rr, ae);
        check_output("stream row reads", 32'(rr), 32'd32);
      end
      begin : stream_cpu
        logic [ADDR_W-1:0] a;
        logic              w;
        logic [DATA_W-1:0] d, srd;
        int sl, sh, swe, lo, hi;
        bit sok;
        for (int k = 0; k < 120; k++) begin
          a = 13'h1000 + ADDR_W'(k * 16) + ADDR_W'($urandom_range(0, 15));
          w = 1'($urandom_range(0, 1));
          d = 16'($urandom);
          cpu_start(w, a, d);
          cpu_wait(10, srd, sl, sh, swe, sok);
          lo = (k == 0) ? 2 : 3;
          hi = (k == 0) ? 4 : 5;
          check_output($sformatf("stream ack seen %0d", k), 32'(sok), 32'd1);
          check_output($sformatf("stream accesses %0d", k), 32'(sh), 32'd1);
          check_output($sformatf("stream latency %0d (got %0d)", k, sl),
                       32'(sl >= lo && sl <= hi), 32'd1);
          if (w) shadow[a] = d;
          else   check_output($sformatf("stream rdata %0d", k), 32'(srd), 32'(shadow[a]));
        end
        bus.cpu_req = 1'b0;
      end
    join

    // Reset lands while a CPU read owns the RAM port; the held request must complete afterwards.
    apply_stimulus(0, 0);
    @(negedge clk);
    cpu_start(1'b0, 13'h1555, 16'h0000);
    @(negedge clk);
    check_output("pre-reset cpu grant", 32'(bus.mem_en), 32'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid-read reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cpu_wait(8, rd, lat, hits, wec, ok);
    check_output("post-reset ack seen", 32'(ok), 32'd1);
    check_output("post-reset latency", 32'(lat), 32'd2);
    check_output("post-reset accesses", 32'(hits), 32'd1);
    check_output("post-reset read data", 32'(rd), 32'(shadow[13'h1555]));
    bus.cpu_req = 1'b0;
    @(negedge clk);
    run_line(111, rr, ae);
    run_line(112, rr, ae);
    check_output("post-reset row reads", 32'(rr), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
